// File: rtl/nr_mem_arb_pkg.sv
// Shared constants for the data-memory arbiter: state codes, requester ids,
// default bus widths and the supported read-latency range.
package nr_mem_arb_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/nr_rr_pick.sv
// Two-way round-robin picker; prio names the requester that wins a tie.
module nr_rr_pick
    import nr_mem_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic prio,
    output logic grant0,
    output logic grant1,
    output logic any
);
    assign grant0 = valid0 && (!valid1 || prio == REQ0);
    assign grant1 = valid1 && (!valid0 || prio == REQ1);
    assign any    = valid0 || valid1;
endmodule

// File: rtl/nr_mem_arbiter.sv
// Two-requester arbiter and access sequencer for the data memory. One command
// is in flight at a time; each command gets a single-cycle response pulse.
module nr_mem_arbiter
    import nr_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic [ADDR_W-1:0] mem_adr_in,
    output logic [DATA_W-1:0] mem_in0,
    output logic              mem_can_wrt,
    output logic [ADDR_W-1:0] mem_adr_out,
    output logic              mem_can_rd,
    input  logic [DATA_W-1:0] mem_out0,
    output logic              busy
);
    // Out-of-range latencies are clamped to what the wait counter can hold.
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    typedef struct packed {
        logic              wr;
        logic              owner;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic [1:0]       state;
    logic             prio;
    logic [CNT_W-1:0] cnt;
    cmd_t             cmd;
    logic [DATA_W-1:0] rdata_q;
    logic grant0, grant1, any_valid, accept, active, resp;

    nr_rr_pick u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .prio   (prio),
        .grant0 (grant0),
        .grant1 (grant1),
        .any    (any_valid)
    );

    // Ready is gated by clr so nothing is offered while reset is held.
    assign accept     = (state == ST_IDLE) && !clr && any_valid;
    assign req0_ready = accept && grant0;
    assign req1_ready = accept && grant1;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= ST_IDLE;
            prio    <= REQ0;
            cnt     <= '0;
            cmd     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd.wr    <= grant1 ? req1_wr    : req0_wr;
                        cmd.addr  <= grant1 ? req1_addr  : req0_addr;
                        cmd.wdata <= grant1 ? req1_wdata : req0_wdata;
                        cmd.owner <= grant1 ? REQ1 : REQ0;
                        prio      <= grant1 ? REQ0 : REQ1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd.wr) begin
                        state <= ST_RESP;
                    end else if (LAT == 1) begin
                        rdata_q <= mem_out0;
                        state   <= ST_RESP;
                    end else begin
                        cnt   <= CNT_W'(LAT - 1);
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rdata_q <= mem_out0;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign active      = (state == ST_ISSUE) || (state == ST_WAIT);
    assign resp        = (state == ST_RESP);
    assign mem_adr_in  = active ? cmd.addr  : '0;
    assign mem_adr_out = active ? cmd.addr  : '0;
    assign mem_in0     = active ? cmd.wdata : '0;
    assign mem_can_wrt = (state == ST_ISSUE) && cmd.wr;
    assign mem_can_rd  = active && !cmd.wr;
    assign busy        = (state != ST_IDLE);

    assign rsp0_valid = resp && (cmd.owner == REQ0);
    assign rsp1_valid = resp && (cmd.owner == REQ1);
    assign rsp0_rdata = (rsp0_valid && !cmd.wr) ? rdata_q : '0;
    assign rsp1_rdata = (rsp1_valid && !cmd.wr) ? rdata_q : '0;
endmodule

// File: tb/tb_nr_mem_arbiter.sv
// Bench for nr_mem_arbiter: two instances (RD_LAT=1 and RD_LAT=3), each with its
// own memory model and a transaction-level reference checked every cycle.
module tb_nr_mem_arbiter;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]      v0, w0, v1, w1;
    logic [1:0][7:0] a0, d0, a1, d1;
    wire  [1:0]      rdy0, rdy1, rv0, rv1, mwr, mrd, bsy;
    wire  [1:0][7:0] rd0, rd1, madi, mdi, mado;
    logic [1:0][7:0] mout;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    nr_mem_arbiter #(.RD_LAT(1)) u_dut_l1 (
        .clk(clk), .clr(clr),
        .req0_valid(v0[0]), .req0_wr(w0[0]), .req0_addr(a0[0]), .req0_wdata(d0[0]),
        .req0_ready(rdy0[0]), .rsp0_valid(rv0[0]), .rsp0_rdata(rd0[0]),
        .req1_valid(v1[0]), .req1_wr(w1[0]), .req1_addr(a1[0]), .req1_wdata(d1[0]),
        .req1_ready(rdy1[0]), .rsp1_valid(rv1[0]), .rsp1_rdata(rd1[0]),
        .mem_adr_in(madi[0]), .mem_in0(mdi[0]), .mem_can_wrt(mwr[0]),
        .mem_adr_out(mado[0]), .mem_can_rd(mrd[0]), .mem_out0(mout[0]), .busy(bsy[0])
    );

    nr_mem_arbiter #(.RD_LAT(3)) u_dut_l3 (
        .clk(clk), .clr(clr),
        .req0_valid(v0[1]), .req0_wr(w0[1]), .req0_addr(a0[1]), .req0_wdata(d0[1]),
        .req0_ready(rdy0[1]), .rsp0_valid(rv0[1]), .rsp0_rdata(rd0[1]),
        .req1_valid(v1[1]), .req1_wr(w1[1]), .req1_addr(a1[1]), .req1_wdata(d1[1]),
        .req1_ready(rdy1[1]), .rsp1_valid(rv1[1]), .rsp1_rdata(rd1[1]),
        .mem_adr_in(madi[1]), .mem_in0(mdi[1]), .mem_can_wrt(mwr[1]),
        .mem_adr_out(mado[1]), .mem_can_rd(mrd[1]), .mem_out0(mout[1]), .busy(bsy[1])
    );

    // Memory model: read data is only valid once the strobe has been held RD_LAT cycles.
    logic [7:0] mem [2][256];
    int rcnt [2] = '{0, 0};
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mwr[d]) mem[d][madi[d]] <= mdi[d];
            rcnt[d] <= mrd[d] ? rcnt[d] + 1 : 0;
        end
    end
    always_comb begin
        mout = '0;
        for (int d = 0; d < 2; d++)
            mout[d] = (mrd[d] && rcnt[d] == lat(d) - 1) ? mem[d][mado[d]] : 8'hEE;
    end

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, d, cyc, act, exp);
    endtask

    // Reference: one command at a time, tracked as issue/response cycle numbers.
    int         m_prio [2], m_free [2], k_iss [2], rsp_cyc [2], m_owner [2];
    logic       m_wr [2];
    logic [7:0] m_addr [2], m_wdata [2], m_rdata [2];
    logic [7:0] ref_mem [2][256];
    bit         acc0 [2], acc1 [2];

    always @(negedge clk) begin : mon
        bit idle, e_r0, e_r1, in_cmd, e_rsp;
        for (int d = 0; d < 2; d++) begin
            if (clr) begin
                m_prio[d] = 0; m_free[d] = 0; k_iss[d] = -1; rsp_cyc[d] = -1;
                acc0[d] = 0; acc1[d] = 0;
                check("rst_ctl", d, {rdy0[d], rdy1[d], rv0[d], rv1[d], mwr[d], mrd[d], bsy[d]}, 0);
                check("rst_bus", d, {rd0[d], rd1[d], madi[d], mdi[d]}, 0);
                check("rst_adr_out", d, mado[d], 0);
            end else begin
                idle   = cyc >= m_free[d];
                e_r0   = idle && v0[d] && (!v1[d] || m_prio[d] == 0);
                e_r1   = idle && v1[d] && (!v0[d] || m_prio[d] == 1);
                in_cmd = !idle && cyc >= k_iss[d] && cyc < rsp_cyc[d];
                e_rsp  = !idle && cyc == rsp_cyc[d];
                check("ready0", d, rdy0[d], e_r0);
                check("ready1", d, rdy1[d], e_r1);
                check("busy", d, bsy[d], !idle);
                check("mem_can_wrt", d, mwr[d], in_cmd && cyc == k_iss[d] && m_wr[d]);
                check("mem_can_rd", d, mrd[d], in_cmd && !m_wr[d]);
                check("mem_adr_in", d, madi[d], in_cmd ? m_addr[d] : 8'h00);
                check("mem_adr_out", d, mado[d], in_cmd ? m_addr[d] : 8'h00);
                if (!(in_cmd && cyc != k_iss[d]))
                    check("mem_in0", d, mdi[d], in_cmd ? m_wdata[d] : 8'h00);
                check("rsp0_valid", d, rv0[d], e_rsp && m_owner[d] == 0);
                check("rsp1_valid", d, rv1[d], e_rsp && m_owner[d] == 1);
                check("rsp0_rdata", d, rd0[d], (e_rsp && m_owner[d] == 0) ? m_rdata[d] : 8'h00);
                check("rsp1_rdata", d, rd1[d], (e_rsp && m_owner[d] == 1) ? m_rdata[d] : 8'h00);
                acc0[d] = v0[d] && rdy0[d];
                acc1[d] = v1[d] && rdy1[d];
                if (e_r0 || e_r1) begin
                    m_owner[d] = e_r1 ? 1 : 0;
                    m_wr[d]    = e_r1 ? w1[d] : w0[d];
                    m_addr[d]  = e_r1 ? a1[d] : a0[d];
                    m_wdata[d] = e_r1 ? d1[d] : d0[d];
                    k_iss[d]   = cyc + 1;
                    rsp_cyc[d] = m_wr[d] ? k_iss[d] + 1 : k_iss[d] + lat(d);
                    m_free[d]  = rsp_cyc[d] + 1;
                    m_rdata[d] = m_wr[d] ? 8'h00 : ref_mem[d][m_addr[d]];
                    if (m_wr[d]) ref_mem[d][m_addr[d]] = m_wdata[d];
                    m_prio[d]  = e_r1 ? 0 : 1;
                end
            end
        end
    end

    typedef struct {
        int         r;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic drive(input int d, input int r, input bit v, input bit wr,
                         input logic [7:0] ad, input logic [7:0] wd);
        if (r == 0) begin v0[d] = v; w0[d] = wr; a0[d] = ad; d0[d] = wd; end
        else        begin v1[d] = v; w1[d] = wr; a1[d] = ad; d1[d] = wd; end
    endtask

    task automatic do_txn(input int d, input vec_t t);
        bit ok; int c0, nwr, nrd, got; logic [7:0] rdat;
        @(posedge clk); #1;
        drive(d, t.r, 1'b1, t.wr, t.addr, t.wdata);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = (t.r == 0) ? rdy0[d] : rdy1[d];
        end
        check("txn_accept", d, ok, 1);
        c0 = cyc;
        @(posedge clk); #1;
        drive(d, t.r, 1'b0, 1'b0, 8'h00, 8'h00);
        ok = 0; nwr = 0; nrd = 0; got = -1; rdat = 8'h00;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            nwr += int'(mwr[d]);
            nrd += int'(mrd[d]);
            if ((t.r == 0) ? rv0[d] : rv1[d]) begin
                ok = 1; got = cyc - c0;
                rdat = (t.r == 0) ? rd0[d] : rd1[d];
            end
        end
        check("txn_latency", d, got, t.wr ? 2 : 1 + lat(d));
        check("txn_rdata", d, rdat, t.exp_rdata);
        check("txn_wr_cycles", d, nwr, t.wr ? 1 : 0);
        check("txn_rd_cycles", d, nrd, t.wr ? 0 : lat(d));
    endtask

    task automatic wait_idle(input int d);
        bit ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = !bsy[d];
        end
        check("reach_idle", d, ok, 1);
    endtask

    task automatic contend(input int d);
        bit ok, g1;
        @(posedge clk); #1;
        drive(d, 0, 1'b1, 1'b0, 8'h01, 8'h00);
        drive(d, 1, 1'b1, 1'b0, 8'h02, 8'h00);
        for (int g = 0; g < 4; g++) begin
            ok = 0; g1 = 0;
            for (int i = 0; i < 20 && !ok; i++) begin
                @(negedge clk);
                ok = rdy0[d] || rdy1[d];
                g1 = rdy1[d];
            end
            check("grant_seen", d, ok, 1);
            check("grant_order", d, g1, g % 2);
            @(posedge clk); #1;
        end
        drive(d, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(d, 1, 1'b0, 1'b0, 8'h00, 8'h00);
        wait_idle(d);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic rnd_req(input int d, input int r);
        bit v, a; logic [7:0] ad;
        v = (r == 0) ? v0[d] : v1[d];
        a = (r == 0) ? acc0[d] : acc1[d];
        if ((v && a && $urandom_range(0, 1) == 0) || (!v && $urandom_range(0, 2) == 0)) begin
            ad = 8'($urandom_range(0, 8));
            if (ad == 8'd8) ad = 8'hFF;
            drive(d, r, 1'b1, 1'($urandom_range(0, 1)), ad, 8'($urandom));
        end else if (v && (a || $urandom_range(0, 7) == 0)) begin
            drive(d, r, 1'b0, 1'b0, 8'h00, 8'h00);
        end
    endtask

    initial begin
        vec_t tbl [7];
        bit ok;
        int diff;
        v0 = '0; w0 = '0; v1 = '0; w1 = '0; a0 = '0; d0 = '0; a1 = '0; d1 = '0;
        for (int d = 0; d < 2; d++) begin
            m_prio[d] = 0; m_free[d] = 0; k_iss[d] = -1; rsp_cyc[d] = -1; m_owner[d] = 0;
            m_wr[d] = 0; m_addr[d] = 0; m_wdata[d] = 0; m_rdata[d] = 0;
            for (int i = 0; i < 256; i++) begin mem[d][i] = 8'h00; ref_mem[d][i] = 8'h00; end
        end
        tbl[0] = '{0, 1'b1, 8'h10, 8'hA5, 8'h00};
        tbl[1] = '{1, 1'b0, 8'h10, 8'h00, 8'hA5};
        tbl[2] = '{0, 1'b1, 8'hFF, 8'hFF, 8'h00};
        tbl[3] = '{0, 1'b0, 8'hFF, 8'h00, 8'hFF};
        tbl[4] = '{1, 1'b0, 8'hFE, 8'h00, 8'h00};
        tbl[5] = '{1, 1'b1, 8'h00, 8'h3C, 8'h00};
        tbl[6] = '{0, 1'b0, 8'h00, 8'h00, 8'h3C};

        repeat (2) @(posedge clk);
        #1 clr = 1'b0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 7; i++) do_txn(d, tbl[i]);

        pulse_clr();
        contend(0);
        contend(1);

        // Reset while the RD_LAT=3 instance is waiting on a read.
        @(posedge clk); #1;
        drive(1, 0, 1'b1, 1'b0, 8'h10, 8'h00);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = rdy0[1]; end
        check("async_setup_accept", 1, ok, 1);
        @(posedge clk); #1;
        drive(1, 0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #1;
        check("async_wait_rd", 1, mrd[1], 1);
        clr = 1'b1;
        #1;
        check("async_rd_drop", 1, mrd[1], 0);
        check("async_busy_drop", 1, bsy[1], 0);
        @(posedge clk); #1 clr = 1'b0;
        repeat (5) @(negedge clk);
        contend(1);

        for (int n = 0; n < 400; n++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                rnd_req(d, 0);
                rnd_req(d, 1);
            end
        end
        v0 = '0; v1 = '0;
        wait_idle(0);
        wait_idle(1);

        for (int d = 0; d < 2; d++) begin
            diff = 0;
            for (int i = 0; i < 256; i++) if (mem[d][i] !== ref_mem[d][i]) diff++;
            check("mem_image", d, diff, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
